lc3_mem_seq: RTL

LC3_MEM_SEQ -- requirements
Module: lc3_mem_seq

---
 rtl/lc3_mem_pkg.sv | 31 +++
 rtl/lc3_mem_timer.sv | 30 +++
 rtl/lc3_mem_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared encodings for the LC-3 memory access sequencer: opcodes, FSM states
// and MarMux select values.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_ST  = 2'b01,
    OP_LDI = 2'b10,
    OP_STI = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACC1 = 2'b01,
    S_ACC2 = 2'b10,
    S_RESP = 2'b11
  } state_e;

  localparam logic MARMUX_IMM  = 1'b0;
  localparam logic MARMUX_ADDR = 1'b1;

  // Indirect ops go through a pointer fetch before the data access.
  function automatic logic is_indirect(input op_e op);
    return op[1];
  endfunction

  function automatic logic is_load(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/lc3_mem_timer.sv
// Per-access wait counter; o_expired flags the last cycle a stalled access may wait.
module lc3_mem_timer
  import lc3_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lc3_mem_seq.sv
// LC-3 memory access sequencer: runs LD/ST/LDI/STI through MAR/MDR with a
// bounded wait on each memory access and a single-cycle response pulse.
module lc3_mem_seq
  import lc3_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic        i_req_src,
  input  logic [15:0] i_req_wdata,
  output logic        o_marmux_sel,
  input  logic [15:0] i_marmux_out,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_busy
);

  state_e      r_state, w_next;
  op_e         r_op;
  logic [15:0] r_mar, r_mdr;
  logic        r_err;
  logic        w_accept, w_in_acc, w_tmr_clr, w_tmr_en, w_expired;

  assign w_accept = (r_state == S_IDLE) && i_req_valid;
  assign w_in_acc = (r_state == S_ACC1) || (r_state == S_ACC2);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_req_valid) w_next = S_ACC1;
      S_ACC1: begin
        if (i_mem_ready)    w_next = is_indirect(r_op) ? S_ACC2 : S_RESP;
        else if (w_expired) w_next = S_RESP;
      end
      S_ACC2: if (i_mem_ready || w_expired) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Any state change restarts the count, so each access gets a fresh budget.
  assign w_tmr_clr = (w_next != r_state);
  assign w_tmr_en  = w_in_acc && !i_mem_ready;

  lc3_mem_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_LD;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mar <= i_marmux_out;
            r_mdr <= i_req_wdata;
            r_op  <= op_e'(i_req_op);
            r_err <= 1'b0;
          end
        end
        S_ACC1: begin
          if (i_mem_ready) begin
            if (r_op == OP_LD)      r_mdr <= i_mem_rdata;
            if (is_indirect(r_op))  r_mar <= i_mem_rdata;
          end else if (w_expired) begin
            r_err <= 1'b1;
          end
        end
        S_ACC2: begin
          if (i_mem_ready) begin
            if (r_op == OP_LDI) r_mdr <= i_mem_rdata;
          end else if (w_expired) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_marmux_sel = (r_state == S_IDLE) ? i_req_src : MARMUX_IMM;
  assign o_mem_en     = w_in_acc;
  assign o_mem_we     = ((r_state == S_ACC1) && (r_op == OP_ST)) ||
                        ((r_state == S_ACC2) && (r_op == OP_STI));
  assign o_mem_addr   = r_mar;
  assign o_mem_wdata  = r_mdr;
  assign o_rsp_valid  = (r_state == S_RESP);
  assign o_rsp_err    = (r_state == S_RESP) && r_err;
  assign o_rsp_data   = ((r_state == S_RESP) && !r_err && is_load(r_op)) ? r_mdr : 16'h0000;

endmodule
